// File: rtl/velocity_pkg.sv
// velocity_pkg: shared constants, FSM state type and velocity saturation helper for the
// velocity memory writer.
//   VEL_DEPTH  - number of velocity entries (flat addresses 0..VEL_DEPTH-1)
//   VEL_W      - velocity width in bits
//   ADDR_W     - write address width
//   LFSR_RESET - LFSR value after reset
//   LFSR_SEED  - LFSR value loaded on refill start when VELOCITY_FIXED_SEED_EN is defined
package velocity_pkg;

  localparam int unsigned VEL_DEPTH = 53;
  localparam int unsigned VEL_W     = 2;
  localparam int unsigned ADDR_W    = 6;

  localparam logic [7:0] LFSR_RESET = 8'h01;
  localparam logic [7:0] LFSR_SEED  = 8'hA5;

  typedef enum logic [1:0] {
    StIdle,
    StFill,
    StHold
  } vel_state_e;

  // Random two-bit velocity plus difficulty bias, saturated at the maximum velocity.
  function automatic logic [VEL_W-1:0] sat_vel(logic [1:0] rnd, logic [1:0] lvl);
    logic [2:0] sum;
    sum = {1'b0, rnd} + {1'b0, lvl};
    return sum[2] ? 2'd3 : sum[1:0];
  endfunction

endpackage

// File: rtl/velocity_mem_writer_if.sv
// velocity_mem_writer_if: request and memory-write signals of the velocity memory writer.
//   start    - one-cycle full refill request
//   level    - difficulty bias, latched when a request is accepted
//   upd_req  - single-entry update request, held until upd_ack
//   upd_col  - entry to re-randomise, sampled with upd_req
//   wr_en    - memory write strobe
//   wr_addr  - flat write address
//   wr_data  - velocity to write
//   busy     - refill in progress
//   done     - one-cycle pulse after the last refill write
//   upd_ack  - one-cycle pulse coincident with the single-entry write
// Modports: master = game controller / memory side, slave = writer.
interface velocity_mem_writer_if;
  import velocity_pkg::*;

  logic              start;
  logic [1:0]        level;
  logic              upd_req;
  logic [ADDR_W-1:0] upd_col;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [VEL_W-1:0]  wr_data;
  logic              busy;
  logic              done;
  logic              upd_ack;

  modport master (
    output start, level, upd_req, upd_col,
    input  wr_en, wr_addr, wr_data, busy, done, upd_ack
  );

  modport slave (
    input  start, level, upd_req, upd_col,
    output wr_en, wr_addr, wr_data, busy, done, upd_ack
  );

endinterface

// File: rtl/vel_lfsr8.sv
// vel_lfsr8: 8-bit Fibonacci LFSR, x^8+x^6+x^5+x^4+1, left shifting, advancing every cycle.
//   clk   - clock
//   rst_n - asynchronous active-low reset, loads LFSR_RESET
//   load  - load seed instead of advancing on this edge
//   seed  - value to load
//   q     - current LFSR state
module vel_lfsr8
  import velocity_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [7:0] seed,
  output logic [7:0] q
);

  logic [7:0] q_d;

  always_comb begin
    q_d = load ? seed : {q[6:0], q[7] ^ q[5] ^ q[4] ^ q[3]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= LFSR_RESET;
    end else begin
      q <= q_d;
    end
  end

endmodule

// File: rtl/velocity_mem_writer.sv
// velocity_mem_writer: produces the write stream that loads the 53-entry velocity memory with
// pseudo-random velocities, either as a full refill or a single-entry re-randomisation.
//   clk   - system clock
//   rst_n - asynchronous active-low reset; abandons any write sequence
//   bus   - velocity_mem_writer_if.slave (requests in, write stream and status out)
// Build option: VELOCITY_FIXED_SEED_EN reloads the LFSR with LFSR_SEED on every accepted start,
// making each refill reproducible. Without it the LFSR free-runs from reset.
module velocity_mem_writer
  import velocity_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  velocity_mem_writer_if.slave   bus
);

  localparam logic [ADDR_W-1:0] DepthA = ADDR_W'(VEL_DEPTH);

  vel_state_e        state_q;
  logic [ADDR_W-1:0] cnt_q;
  logic [ADDR_W-1:0] col_q;
  logic [1:0]        level_q;
  logic              pend_q;

  logic              wr_en_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [VEL_W-1:0]  wr_data_q;
  logic              busy_q;
  logic              done_q;
  logic              upd_ack_q;

  logic [7:0]        lfsr;
  logic              lfsr_load;
  logic              start_accept;
  logic [VEL_W-1:0]  vel;
  logic              unused_lfsr;

  assign start_accept = (state_q == StIdle) && bus.start;

`ifdef VELOCITY_FIXED_SEED_EN
  assign lfsr_load = start_accept;
`else
  assign lfsr_load = 1'b0;
`endif

  vel_lfsr8 u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (lfsr_load),
    .seed  (LFSR_SEED),
    .q     (lfsr)
  );

  // Uses the LFSR value present before this edge's advance.
  assign vel         = sat_vel(lfsr[1:0], level_q);
  assign unused_lfsr = ^lfsr[7:2];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      col_q     <= '0;
      level_q   <= '0;
      pend_q    <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      upd_ack_q <= 1'b0;
    end else begin
      wr_en_q   <= 1'b0;
      done_q    <= 1'b0;
      upd_ack_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start_accept) begin
            level_q <= bus.level;
            cnt_q   <= '0;
            state_q <= StFill;
          end else if (bus.upd_req && (bus.upd_col < DepthA)) begin
            level_q <= bus.level;
            col_q   <= bus.upd_col;
            pend_q  <= 1'b1;
            state_q <= StHold;
          end
        end
        StFill: begin
          // cnt_q runs one past the last address so done lands the cycle after the final write.
          if (cnt_q == DepthA) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= StIdle;
          end else begin
            wr_en_q   <= 1'b1;
            wr_addr_q <= cnt_q;
            wr_data_q <= vel;
            busy_q    <= 1'b1;
            cnt_q     <= cnt_q + ADDR_W'(1);
          end
        end
        StHold: begin
          // Issue the accepted write once, then wait for the requester to drop upd_req so a
          // still-held request is not acked a second time.
          if (pend_q) begin
            pend_q    <= 1'b0;
            wr_en_q   <= 1'b1;
            upd_ack_q <= 1'b1;
            wr_addr_q <= col_q;
            wr_data_q <= vel;
          end else if (!bus.upd_req) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.wr_en   = wr_en_q;
  assign bus.wr_addr = wr_addr_q;
  assign bus.wr_data = wr_data_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.upd_ack = upd_ack_q;

endmodule

// File: tb/tb_velocity_mem_writer.sv
// tb_velocity_mem_writer: directed/randomised bench for velocity_mem_writer. A free-running
// LFSR model supplies the random source; expected velocities are min(3, rnd + level).
module tb_velocity_mem_writer;
  import velocity_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks   = 0;
  int   failures = 0;

  velocity_mem_writer_if bus ();

  velocity_mem_writer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference random source: value before each edge's advance is kept in m_prev.
  logic [7:0] m_lfsr;
  logic [7:0] m_prev;
  logic       m_seed = 1'b0;

  function automatic logic [7:0] lfsr_step(logic [7:0] v);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_lfsr <= 8'h01;
      m_prev <= 8'h01;
    end else begin
      m_prev <= m_lfsr;
      m_lfsr <= m_seed ? 8'hA5 : lfsr_step(m_lfsr);
    end
  end

  function automatic int exp_vel(int lvl, logic [7:0] r);
    int s;
    s = int'(r[1:0]) + lvl;
    return (s > 3) ? 3 : s;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Full refill starting on the current negedge. Optionally holds an update request alongside
  // start, or pulls reset after write index rst_at (then returns with reset asserted).
  task automatic do_refill(input int lvl, input bit with_upd, input logic [5:0] col,
                           input int rst_at);
    bus.start = 1'b1;
    bus.level = lvl[1:0];
    if (with_upd) begin
      bus.upd_req = 1'b1;
      bus.upd_col = col;
    end
`ifdef VELOCITY_FIXED_SEED_EN
    m_seed = 1'b1;
`endif
    @(negedge clk);
    bus.start = 1'b0;
    m_seed    = 1'b0;
    if (!with_upd) bus.level = 2'($urandom_range(0, 3));
    chk("fill_lag_wr_en", bus.wr_en, 0);
    chk("fill_lag_busy", bus.busy, 0);
    chk("done_one_cycle", bus.done, 0);
    for (int i = 0; i < 53; i++) begin
      @(negedge clk);
      chk("fill_wr_en", bus.wr_en, 1);
      chk("fill_addr", bus.wr_addr, i);
      chk("fill_data", bus.wr_data, exp_vel(lvl, m_prev));
      chk("fill_busy", bus.busy, 1);
      chk("fill_done", bus.done, 0);
      chk("fill_no_ack", bus.upd_ack, 0);
`ifdef VELOCITY_FIXED_SEED_EN
      if (lvl == 0 && i < 2) chk("seed_data", bus.wr_data, i + 1);
`endif
      if (i == rst_at) begin
        rst_n = 1'b0;
        #1;
        chk("rst_wr_en", bus.wr_en, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_addr", bus.wr_addr, 0);
        return;
      end
    end
    @(negedge clk);
    chk("done_pulse", bus.done, 1);
    chk("done_busy", bus.busy, 0);
    chk("done_wr_en", bus.wr_en, 0);
    if (with_upd) begin
      @(negedge clk);
      chk("post_fill_ack_early", bus.upd_ack, 0);
      chk("post_fill_wr_early", bus.wr_en, 0);
      @(negedge clk);
      chk("post_fill_ack", bus.upd_ack, 1);
      chk("post_fill_wr_en", bus.wr_en, 1);
      chk("post_fill_addr", bus.wr_addr, col);
      chk("post_fill_data", bus.wr_data, exp_vel(lvl, m_prev));
      bus.upd_req = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("post_fill_release", bus.wr_en, 0);
    end
  endtask

  // Single-entry update held for 'hold' cycles (hold >= 2), then released.
  task automatic do_update(input logic [5:0] col, input int lvl, input int hold);
    bus.upd_req = 1'b1;
    bus.upd_col = col;
    bus.level   = lvl[1:0];
    for (int c = 1; c <= hold; c++) begin
      @(negedge clk);
      if (col < 53 && c == 2) begin
        chk("upd_ack", bus.upd_ack, 1);
        chk("upd_wr_en", bus.wr_en, 1);
        chk("upd_addr", bus.wr_addr, col);
        chk("upd_data", bus.wr_data, exp_vel(lvl, m_prev));
      end else begin
        chk("upd_no_ack", bus.upd_ack, 0);
        chk("upd_no_wr", bus.wr_en, 0);
      end
      chk("upd_not_busy", bus.busy, 0);
    end
    bus.upd_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("upd_release_idle", bus.wr_en, 0);
  endtask

  initial begin
    bus.start   = 1'b0;
    bus.level   = 2'd0;
    bus.upd_req = 1'b0;
    bus.upd_col = '0;
    repeat (3) @(negedge clk);
    chk("reset_wr_en", bus.wr_en, 0);
    chk("reset_wr_addr", bus.wr_addr, 0);
    chk("reset_wr_data", bus.wr_data, 0);
    chk("reset_busy", bus.busy, 0);
    chk("reset_done", bus.done, 0);
    chk("reset_upd_ack", bus.upd_ack, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Level 0, then level 3 back-to-back (start on the done cycle, saturated data).
    do_refill(0, 1'b0, '0, -1);
    do_refill(3, 1'b0, '0, -1);
    repeat (3) @(negedge clk);

    // Held update acked once, then acked again after release and reassert.
    do_update(6'd17, int'($urandom_range(0, 3)), 4);
    do_update(6'd17, int'($urandom_range(0, 3)), 4);
    for (int n = 0; n < 6; n++) begin
      do_update(6'($urandom_range(0, 52)), int'($urandom_range(0, 3)),
                int'($urandom_range(2, 5)));
    end
    do_update(6'd52, int'($urandom_range(0, 3)), 3);

    // Out-of-range columns are neither written nor acked.
    do_update(6'd53, 0, 5);
    do_update(6'($urandom_range(54, 63)), 1, 4);
    do_update(6'd0, int'($urandom_range(0, 3)), 3);

    // start and upd_req together: refill wins, update acked after done.
    do_refill(int'($urandom_range(0, 3)), 1'b1, 6'($urandom_range(0, 52)), -1);

    for (int n = 0; n < 3; n++) begin
      do_refill(int'($urandom_range(0, 3)), 1'b0, '0, -1);
    end

    // Reset at write 20 abandons the refill; nothing is written until a new start.
    do_refill(int'($urandom_range(0, 3)), 1'b0, '0, 20);
    @(negedge clk);
    rst_n = 1'b1;
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      chk("post_rst_no_wr", bus.wr_en, 0);
      chk("post_rst_not_busy", bus.busy, 0);
    end
    do_refill(int'($urandom_range(0, 3)), 1'b0, '0, -1);
    repeat (2) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
